// File: rtl/mpadd_sched.sv
// Round-robin scheduler sharing one write/start/ready multi-precision adder among NREQ requesters.
// Optional statistics outputs (op_count, err_count) are built when MPADD_SCHED_STATS_EN is defined.
module mpadd_sched #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned WIDTH   = 1024,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_req,
  input  logic [NREQ*WIDTH-1:0] b_req,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH:0]        rsp_data,
  output logic                  rsp_err,
  input  logic [NREQ-1:0]       rsp_ack,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  output logic                  add_write,
  output logic                  add_start,
  input  logic [WIDTH:0]        add_sum,
  input  logic                  add_ready,
  output logic                  busy
`ifdef MPADD_SCHED_STATS_EN
  ,
  output logic [31:0]           op_count,
  output logic [15:0]           err_count
`endif
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    RESP
  } state_e;

  state_e            state_q;
  logic [IW-1:0]     idx_q;
  logic [IW-1:0]     rr_q;
  logic [7:0]        tmo_q;
  logic [7:0]        tmo_inc;
  logic [NREQ-1:0]   gnt_q;
  logic [NREQ-1:0]   rsp_valid_q;
  logic [WIDTH:0]    rsp_data_q;
  logic              rsp_err_q;
  logic              add_write_q;
  logic              add_start_q;
  logic              busy_q;
  logic [WIDTH-1:0]  hold_a_q;
  logic [WIDTH-1:0]  hold_b_q;

  logic              found;
  logic [IW-1:0]     win;
  logic [IW:0]       cand;
  logic [WIDTH-1:0]  a_slot;
  logic [WIDTH-1:0]  b_slot;
  logic [IW-1:0]     rr_next;

`ifdef MPADD_SCHED_STATS_EN
  logic [31:0]       op_count_q;
  logic [15:0]       err_count_q;
`endif

  // First set request at or above the rr pointer, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = {1'b0, rr_q} + (IW+1)'(i);
      if (cand >= (IW+1)'(NREQ)) begin
        cand = cand - (IW+1)'(NREQ);
      end
      if (!found && req[cand[IW-1:0]]) begin
        found = 1'b1;
        win   = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    a_slot = '0;
    b_slot = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (idx_q == IW'(i)) begin
        a_slot = a_req[i*WIDTH +: WIDTH];
        b_slot = b_req[i*WIDTH +: WIDTH];
      end
    end
  end

  assign rr_next = (idx_q == IW'(NREQ-1)) ? '0 : idx_q + 1'b1;
  assign tmo_inc = tmo_q + 8'd1;

  // Operands pass straight through in LOAD so the adder sees the values present in the grant cycle.
  assign add_a = (state_q == LOAD) ? a_slot : hold_a_q;
  assign add_b = (state_q == LOAD) ? b_slot : hold_b_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      rr_q        <= '0;
      tmo_q       <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      add_write_q <= 1'b0;
      add_start_q <= 1'b0;
      busy_q      <= 1'b0;
      hold_a_q    <= '0;
      hold_b_q    <= '0;
`ifdef MPADD_SCHED_STATS_EN
      op_count_q  <= '0;
      err_count_q <= '0;
`endif
    end else begin
      gnt_q       <= '0;
      add_write_q <= 1'b0;
      add_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (found) begin
            idx_q       <= win;
            gnt_q       <= NREQ'(1) << win;
            add_write_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= LOAD;
          end
        end
        LOAD: begin
          hold_a_q    <= a_slot;
          hold_b_q    <= b_slot;
          rr_q        <= rr_next;
          add_start_q <= 1'b1;
          state_q     <= START;
        end
        START: begin
          tmo_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (add_ready) begin
            rsp_data_q  <= add_sum;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= NREQ'(1) << idx_q;
            state_q     <= RESP;
          end else if (tmo_inc == 8'(TIMEOUT)) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= NREQ'(1) << idx_q;
            state_q     <= RESP;
`ifdef MPADD_SCHED_STATS_EN
            if (err_count_q != '1) begin
              err_count_q <= err_count_q + 16'd1;
            end
`endif
          end else begin
            tmo_q <= tmo_inc;
          end
        end
        RESP: begin
          if (rsp_ack[idx_q]) begin
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
`ifdef MPADD_SCHED_STATS_EN
            if (!rsp_err_q && op_count_q != '1) begin
              op_count_q <= op_count_q + 32'd1;
            end
`endif
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign add_write = add_write_q;
  assign add_start = add_start_q;
  assign busy      = busy_q;

`ifdef MPADD_SCHED_STATS_EN
  assign op_count  = op_count_q;
  assign err_count = err_count_q;
`endif

endmodule

// File: doc/mpadd_sched.md
Name: mpadd_sched

Overview:
- Round-robin scheduler that shares one wide multi-precision adder among NREQ requesters.
- The adder uses a write/start/ready protocol: write loads operands, start computes a registered sum, ready pulses on completion.
- Per operation, the scheduler arbitrates, drives write then start, waits for ready, and returns the WIDTH+1-bit sum to the winning requester with a valid/ack handshake.
- Sits between crypto/bignum clients and the shared adder instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 1024, operand width in bits.
- TIMEOUT, 15, max cycles in WAIT before aborting with error (1..255).

Ports:
- CLK  in  1  clock, all logic on rising edge.
- RST_N  in  1  synchronous active-low reset.
- req  in  NREQ  per-requester add request; requester holds req and operands until its gnt bit.
- a_req  in  NREQ*WIDTH  operand A, requester i in bits [i*WIDTH +: WIDTH].
- b_req  in  NREQ*WIDTH  operand B, same packing.
- gnt  out  NREQ  one-hot, one-cycle pulse; operands consumed that cycle.
- rsp_valid  out  NREQ  one-hot, high until matching rsp_ack.
- rsp_data  out  WIDTH+1  sum for the responding requester.
- rsp_err  out  1  qualifies rsp_valid; 1 = adder timeout, rsp_data = 0.
- rsp_ack  in  NREQ  requester accepts its response.
- add_a  out  WIDTH  adder operand A.
- add_b  out  WIDTH  adder operand B.
- add_write  out  1  adder operand load strobe.
- add_start  out  1  adder start strobe.
- add_sum  in  WIDTH+1  adder result.
- add_ready  in  1  adder done; registered, high the cycle after start.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, RST_N=0 at a rising edge), from any state including mid-operation:
  - FSM goes to IDLE; rr pointer = 0.
  - gnt, rsp_valid, rsp_err, add_write, add_start and busy all 0.
  - rsp_data = 0; timeout counter = 0.
  - The adder's in-flight result is discarded.
- FSM states: IDLE, LOAD, START, WAIT, RESP.
- IDLE:
  - If any req bit is set, pick the winner: the first set bit searching upward from the rr pointer, wrapping modulo NREQ.
  - Register the winner index `idx`; next state LOAD.
  - If no req bit is set, stay in IDLE.
- LOAD (one cycle):
  - gnt[idx] = 1, add_write = 1.
  - add_a/add_b are muxed from slot idx of a_req/b_req.
  - rr pointer = (idx+1) mod NREQ.
  - Next state START.
- START (one cycle): add_start = 1, add_write = 0; next state WAIT.
- WAIT:
  - add_start = 0; the timeout counter increments each cycle.
  - On add_ready: rsp_data <= add_sum, rsp_err <= 0, next state RESP.
  - If the counter reaches TIMEOUT without add_ready: rsp_data <= 0, rsp_err <= 1, next state RESP.
- RESP:
  - rsp_valid[idx] = 1 while rsp_data/rsp_err are held stable.
  - On rsp_ack[idx]: clear rsp_valid, next state IDLE.
  - rsp_ack bits other than idx are ignored.
- Outside LOAD, add_a/add_b hold their last value (no toggling).
- Latency with the standard adder:
  - req high at cycle T (in IDLE) -> gnt/add_write at T+1 -> add_start at T+2.
  - add_ready at T+3 -> rsp_valid at T+4.
  - Minimum service period is 5 cycles per operation; ack-to-next-grant adds one IDLE cycle.
- Width rule: the sum is a full WIDTH+1-bit unsigned value, with the carry out in bit WIDTH.
- Boundary conditions:
  - All req bits set: strict rotation 0,1,2,3,0,...
  - Single requester re-requesting is served back to back.
  - rsp_ack in the same cycle as new req bits: return to IDLE, arbitrate in the following cycle.
  - A req that drops before its gnt is a protocol violation; the operation still completes using whatever operands are present in LOAD.
  - add_ready outside WAIT is ignored.

Optional Feature:
- Macro MPADD_SCHED_STATS_EN.
- When defined, adds two outputs, both reset to 0 and saturating at all-ones:
  - op_count (32 bits): increments on each successful rsp_ack.
  - err_count (16 bits): increments on each timeout.
- When undefined, these ports and counters are absent and the rest of the behaviour is identical.

Test Plan:
- Single request: req=0001, a=all-ones, b=1 -> gnt=0001 at T+1, rsp_valid=0001 at T+4, rsp_data = 2^1024 (bit 1024 set, rest 0), rsp_err=0.
- Round robin: req=1111 held, each response acked at once -> grant order 0,1,2,3,0; rsp_data = a+b per slot, with a=i+1 and b=16*(i+1).
- Fairness after grant: req=0101, requester 0 served, then req=0101 again -> requester 2 granted next, then requester 0.
- Timeout: adder model never asserts add_ready, req=0010 -> after 15 WAIT cycles, rsp_valid=0010, rsp_err=1, rsp_data=0; err_count=1 when stats are enabled.
- Reset mid-operation: RST_N=0 during WAIT -> next cycle all outputs 0, busy=0; a late add_ready is ignored; the next req=1000 gets a grant with the pointer starting at 0.
- Held response: rsp_ack withheld for 10 cycles, other req bits high -> rsp_valid and rsp_data stable, no gnt issued until ack.
